qr_mgs_sequencer: RTL and testbench

- Sequences one 4x4 complex modified Gram-Schmidt QR pass through two shared engines: the column normaliser and the dot/subtract engine.
- Issues one operation at a time: type plus column indices. Waits for the engine's completion pulse, then emits an R-matrix write address.
- Optionally treats the received vector y as an extra column, producing Q^H y.
- Sits between the top-level controller and the column register file / R buffer. Carries no datapath.

---
 rtl/qr_mgs_sequencer.sv | 160 ++++++++++++++++
 tb/tb_qr_mgs_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/qr_mgs_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : qr_mgs_sequencer
//  Description : Issues the operation sequence of one 4x4 complex modified
//                Gram-Schmidt QR pass (NORM / DOT_SUB / DOT_ONLY) to the
//                shared engines, one at a time, and emits an R-matrix write
//                strobe after each engine completion. When requested, the
//                received vector y is handled as an extra column.
//  Revision    : 1.0 - initial release
// ============================================================================
module qr_mgs_sequencer #(
    parameter int N_COL   = 4,
    parameter int TIMEOUT = 63
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_with_y,
    input  logic       i_abort,
    input  logic       i_op_done,
    output logic       o_op_valid,
    output logic [1:0] o_op_type,
    output logic [2:0] o_q_idx,
    output logic [2:0] o_h_idx,
    output logic       o_r_we,
    output logic [2:0] o_r_row,
    output logic [2:0] o_r_col,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_issue = 3'd1;
    localparam logic [2:0] c_wait  = 3'd2;
    localparam logic [2:0] c_write = 3'd3;
    localparam logic [2:0] c_done  = 3'd4;

    localparam logic [1:0] c_op_norm    = 2'd0;
    localparam logic [1:0] c_op_dot     = 2'd1;
    localparam logic [1:0] c_op_dot_sub = 2'd2;

    // Index N_COL selects the y column; N_COL-1 is the last matrix column.
    localparam logic [2:0]    c_y_idx   = 3'(N_COL);
    localparam logic [2:0]    c_last_j  = 3'(N_COL - 1);
    localparam logic [CW-1:0] c_timeout = CW'(TIMEOUT);

    logic [2:0]    state_q, state_d;
    logic [2:0]    j_q, j_d;
    logic [2:0]    k_q, k_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          with_y_q, with_y_d;
    logic          err_q, err_d;

    logic [2:0] w_last_k;
    logic [1:0] w_op_type;
    logic       w_active;

    // Per-j last column index and the type of the current operation.
    always_comb begin
        w_last_k = with_y_q ? c_y_idx : c_last_j;
        if (k_q == j_q)
            w_op_type = c_op_norm;
        else if ((j_q == c_last_j) && (k_q == c_y_idx))
            w_op_type = c_op_dot;      // final y op: nothing left to update
        else
            w_op_type = c_op_dot_sub;
    end

    // Next-state logic; abort outranks every other event in the same cycle.
    always_comb begin
        state_d  = state_q;
        j_d      = j_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        with_y_d = with_y_q;
        err_d    = err_q;
        case (state_q)
            c_idle: begin
                if (!i_abort && i_start) begin
                    with_y_d = i_with_y;
                    j_d      = 3'd0;
                    k_d      = 3'd0;
                    err_d    = 1'b0;
                    state_d  = c_issue;
                end
            end
            c_issue: begin
                cnt_d   = '0;
                state_d = i_abort ? c_idle : c_wait;
            end
            c_wait: begin
                if (i_abort) begin
                    state_d = c_idle;
                end else if (i_op_done) begin
                    state_d = c_write;
                end else if (cnt_q == c_timeout) begin
                    err_d   = 1'b1;
                    state_d = c_idle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            c_write: begin
                if (i_abort) begin
                    state_d = c_idle;
                end else if (k_q < w_last_k) begin
                    k_d     = k_q + 3'd1;
                    state_d = c_issue;
                end else if (j_q < c_last_j) begin
                    j_d     = j_q + 3'd1;
                    k_d     = j_q + 3'd1;
                    state_d = c_issue;
                end else begin
                    state_d = c_done;
                end
            end
            c_done:  state_d = c_idle;
            default: state_d = c_idle;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= c_idle;
            j_q      <= 3'd0;
            k_q      <= 3'd0;
            cnt_q    <= '0;
            with_y_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            j_q      <= j_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            with_y_q <= with_y_d;
            err_q    <= err_d;
        end
    end

    // Outputs decode directly from state so reset clears them at once.
    always_comb begin
        w_active   = (state_q == c_issue) || (state_q == c_wait) || (state_q == c_write);
        o_op_valid = (state_q == c_issue);
        o_op_type  = w_active ? w_op_type : 2'd0;
        o_q_idx    = w_active ? j_q : 3'd0;
        o_h_idx    = w_active ? k_q : 3'd0;
        o_r_we     = (state_q == c_write) && !i_abort;
        o_r_row    = (state_q == c_write) ? j_q : 3'd0;
        o_r_col    = (state_q == c_write) ? k_q : 3'd0;
        o_busy     = (state_q != c_idle);
        o_done     = (state_q == c_done) && !i_abort;
        o_err      = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_qr_mgs_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qr_mgs_sequencer
//  Description : Scoreboard bench for qr_mgs_sequencer with a 5-cycle engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qr_mgs_sequencer;

    logic       i_clk = 1'b0;
    logic       i_rst, i_start, i_with_y, i_abort, i_op_done;
    logic       o_op_valid, o_r_we, o_busy, o_done, o_err;
    logic [1:0] o_op_type;
    logic [2:0] o_q_idx, o_h_idx, o_r_row, o_r_col;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] exp_ops[$];
    logic [5:0] exp_wr[$];

    localparam int M_NORMAL = 0, M_HANG = 1, M_ABORT = 2, M_SPUR = 3, M_RST = 4;

    qr_mgs_sequencer #(.N_COL(4), .TIMEOUT(63)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_with_y(i_with_y),
        .i_abort(i_abort), .i_op_done(i_op_done), .o_op_valid(o_op_valid),
        .o_op_type(o_op_type), .o_q_idx(o_q_idx), .o_h_idx(o_h_idx),
        .o_r_we(o_r_we), .o_r_row(o_r_row), .o_r_col(o_r_col),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference op order: NORM(j), DOT_SUB(j,k>j), then optional y op.
    task automatic build_expected(input bit y);
        exp_ops.delete();
        exp_wr.delete();
        for (int j = 0; j < 4; j++) begin
            exp_ops.push_back({2'd0, 3'(j), 3'(j)});
            exp_wr.push_back({3'(j), 3'(j)});
            for (int k = j + 1; k < 4; k++) begin
                exp_ops.push_back({2'd2, 3'(j), 3'(k)});
                exp_wr.push_back({3'(j), 3'(k)});
            end
            if (y) begin
                exp_ops.push_back({(j == 3) ? 2'd1 : 2'd2, 3'(j), 3'd4});
                exp_wr.push_back({3'(j), 3'd4});
            end
        end
    endtask

    task automatic run(input bit y, input int mode, input int sel);
        int n_exp, op_idx, ops, wrs, dones, cyc, valid_cyc;
        bit ended;
        logic [7:0] e_op;
        logic [5:0] e_wr;
        build_expected(y);
        n_exp = exp_ops.size();
        op_idx = -1; ops = 0; wrs = 0; dones = 0; cyc = 0; valid_cyc = 0; ended = 0;
        if (mode == M_SPUR) begin
            i_op_done = 1'b1;
            @(posedge i_clk); #1;
            i_op_done = 1'b0;
            check_val("spur_idle_busy", {31'd0, o_busy}, 32'd0);
        end
        i_with_y = y;
        i_start  = 1'b1;
        @(posedge i_clk); #1;
        i_start  = 1'b0;
        i_with_y = 1'b0;
        check_val("busy_after_start", {31'd0, o_busy}, 32'd1);
        check_val("valid_after_start", {31'd0, o_op_valid}, 32'd1);
        check_val("err_cleared", {31'd0, o_err}, 32'd0);
        while (!ended && cyc < 3000) begin
            if (o_op_valid) begin
                ops++; op_idx++; valid_cyc = cyc;
                if (exp_ops.size() == 0) check_val("op_overflow", ops, n_exp);
                else begin
                    e_op = exp_ops.pop_front();
                    check_val("op_seq", {24'd0, o_op_type, o_q_idx, o_h_idx}, {24'd0, e_op});
                end
            end
            if (o_r_we) begin
                wrs++;
                if (exp_wr.size() == 0) check_val("wr_overflow", wrs, n_exp);
                else begin
                    e_wr = exp_wr.pop_front();
                    check_val("wr_seq", {26'd0, o_r_row, o_r_col}, {26'd0, e_wr});
                end
                if (mode == M_RST && op_idx == sel) begin
                    #1 i_rst = 1'b1;
                    #1;
                    check_val("rst_we_drop", {31'd0, o_r_we}, 32'd0);
                    check_val("rst_outputs", {13'd0, o_op_valid, o_op_type, o_q_idx, o_h_idx,
                              o_r_we, o_r_row, o_r_col, o_busy, o_done, o_err}, 32'd0);
                    #1 i_rst = 1'b0;
                    ended = 1;
                end
            end
            if (!ended) begin
                if (o_done) begin
                    dones++;
                    ended = 1;
                end else if (!o_busy) begin
                    ended = 1;
                end
            end
            if (!ended) begin
                i_op_done = (op_idx >= 0) && (cyc - valid_cyc == 5) && !(mode == M_HANG && op_idx == sel);
                if (mode == M_ABORT && op_idx == sel && cyc - valid_cyc == 5) i_abort = 1'b1;
                if (mode == M_SPUR && o_op_valid) i_op_done = 1'b1;
                if (mode == M_SPUR && cyc == 17) i_start = 1'b1;
                @(posedge i_clk); #1;
                i_op_done = 1'b0;
                i_abort   = 1'b0;
                i_start   = 1'b0;
                cyc++;
            end
        end
        check_val("run_ended", {31'd0, ended}, 32'd1);
        case (mode)
            M_NORMAL, M_SPUR: begin
                check_val("op_count", ops, n_exp);
                check_val("wr_count", wrs, n_exp);
                check_val("done_count", dones, 1);
                check_val("err_clean", {31'd0, o_err}, 32'd0);
                @(posedge i_clk); #1;
                check_val("idle_after_done", {30'd0, o_busy, o_done}, 32'd0);
            end
            M_HANG: begin
                check_val("hang_ops", ops, sel + 1);
                check_val("hang_done", dones, 0);
                check_val("hang_err", {31'd0, o_err}, 32'd1);
                check_val("hang_busy", {31'd0, o_busy}, 32'd0);
                check_val("hang_latency", cyc - valid_cyc, 65);
            end
            M_ABORT: begin
                check_val("abort_ops", ops, sel + 1);
                check_val("abort_wrs", wrs, sel);
                check_val("abort_done", dones, 0);
                check_val("abort_busy", {31'd0, o_busy}, 32'd0);
                check_val("abort_err", {31'd0, o_err}, 32'd0);
            end
            default: begin
                check_val("rst_wrs", wrs, sel + 1);
            end
        endcase
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_with_y = 1'b0; i_abort = 1'b0; i_op_done = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check_val("reset_outputs", {13'd0, o_op_valid, o_op_type, o_q_idx, o_h_idx,
                  o_r_we, o_r_row, o_r_col, o_busy, o_done, o_err}, 32'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        run(1'b0, M_NORMAL, 0);
        run(1'b1, M_NORMAL, 0);
        run(1'b0, M_HANG,   3);
        run(1'b0, M_NORMAL, 0);
        run(1'b0, M_ABORT,  2);
        run(1'b0, M_NORMAL, 0);
        run(1'b1, M_SPUR,   0);
        run(1'b0, M_RST,    3);
        run(1'b1, M_NORMAL, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
